mem_access_stage: RTL and testbench

Memory-access stage of the five-stage pipeline: consumes the EX/MEM register outputs, performs byte/halfword/word loads and stores against an internal synchronous data RAM with a configurable wait-state latency, and registers the result into the MEM/WB pipeline register. While a memory access is waiting, it stalls the upstream pipeline and inserts bubbles downstream.

---
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores against an internal
// wait-stated data RAM, registered into MEM/WB. Optional macro: MEM_MISALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ME_RegWrite,
  input  logic        ME_MemtoReg,
  input  logic        ME_MemWrite,
  input  logic [4:0]  ME_WriteReg,
  input  logic [31:0] ME_ALUanswer,
  input  logic [31:0] ME_Qb,
  input  logic [2:0]  ME_load_option,
  input  logic [1:0]  ME_save_option,
  input  logic [31:0] ME_PC,
  output logic        ME_stall,
  output logic        WB_RegWrite,
  output logic        WB_MemtoReg,
  output logic [4:0]  WB_WriteReg,
  output logic [31:0] WB_ALUanswer,
  output logic [31:0] WB_MemData,
  output logic [31:0] WB_PC,
  output logic        WB_AddrErr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_C = 4'(MEM_LATENCY);

  logic [31:0] ram_q [DEPTH_WORDS];

  logic          mem_op, is_store, is_load, misalign, ram_we;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   rd_word, wr_word, ld_data;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic [3:0]    cnt_q, cnt_d;

  logic        wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d, wb_err_q, wb_err_d;
  logic [4:0]  wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_alu_q, wb_alu_d, wb_md_q, wb_md_d, wb_pc_q, wb_pc_d;

  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, ME_ALUanswer[31:AW+2]};

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  sb;
    logic signed [31:0] r;
    sb = b;
    r  = sb;
    return sgn ? r : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    logic signed [31:0] r;
    sh = h;
    r  = sh;
    return sgn ? r : {16'd0, h};
  endfunction

  assign is_store = ME_MemWrite;
  assign is_load  = ME_MemtoReg & ~ME_MemWrite;
  assign mem_op   = ME_MemtoReg | ME_MemWrite;
  assign ME_stall = mem_op && (cnt_q != LAT_C);

  assign widx    = ME_ALUanswer[AW+1:2];
  assign lane    = ME_ALUanswer[1:0];
  assign rd_word = ram_q[widx];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane)
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    case (ME_load_option)
      3'd1:    ld_data = ext8(rd_byte, 1'b1);
      3'd2:    ld_data = ext8(rd_byte, 1'b0);
      3'd3:    ld_data = ext16(rd_half, 1'b1);
      3'd4:    ld_data = ext16(rd_half, 1'b0);
      default: ld_data = rd_word;
    endcase
  end

  // Read-modify-write merge: untouched lanes keep the current RAM contents.
  always_comb begin
    wr_word = ME_Qb;
    case (ME_save_option)
      2'd1: begin
        wr_word = rd_word;
        case (lane)
          2'd0: wr_word[7:0]   = ME_Qb[7:0];
          2'd1: wr_word[15:8]  = ME_Qb[7:0];
          2'd2: wr_word[23:16] = ME_Qb[7:0];
          2'd3: wr_word[31:24] = ME_Qb[7:0];
          default: wr_word = rd_word;
        endcase
      end
      2'd2: wr_word = lane[1] ? {ME_Qb[15:0], rd_word[15:0]} : {rd_word[31:16], ME_Qb[15:0]};
      default: wr_word = ME_Qb;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (is_store) begin
      case (ME_save_option)
        2'd1:    misalign = 1'b0;
        2'd2:    misalign = lane[0];
        default: misalign = |lane;
      endcase
    end else if (is_load) begin
      case (ME_load_option)
        3'd1, 3'd2: misalign = 1'b0;
        3'd3, 3'd4: misalign = lane[0];
        default:    misalign = |lane;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // A store mid-wait when reset hits never reaches the RAM.
  assign ram_we = is_store & ~ME_stall & ~misalign & ~reset;

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[widx] <= wr_word;
  end

  always_comb begin
    cnt_d     = cnt_q;
    wb_rw_d   = 1'b0;
    wb_m2r_d  = 1'b0;
    wb_wreg_d = 5'd0;
    wb_alu_d  = 32'd0;
    wb_md_d   = 32'd0;
    wb_pc_d   = 32'd0;
    wb_err_d  = 1'b0;
    if (ME_stall) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d     = 4'd0;
      wb_rw_d   = ME_RegWrite & ~misalign;
      wb_m2r_d  = ME_MemtoReg;
      wb_wreg_d = ME_WriteReg;
      wb_alu_d  = ME_ALUanswer;
      wb_md_d   = (is_load && !misalign) ? ld_data : 32'd0;
      wb_pc_d   = ME_PC;
      wb_err_d  = misalign;
    end
  end

  // MEM/WB pipeline register boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      wb_rw_q   <= 1'b0;
      wb_m2r_q  <= 1'b0;
      wb_wreg_q <= 5'd0;
      wb_alu_q  <= 32'd0;
      wb_md_q   <= 32'd0;
      wb_pc_q   <= 32'd0;
      wb_err_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wb_rw_q   <= wb_rw_d;
      wb_m2r_q  <= wb_m2r_d;
      wb_wreg_q <= wb_wreg_d;
      wb_alu_q  <= wb_alu_d;
      wb_md_q   <= wb_md_d;
      wb_pc_q   <= wb_pc_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign WB_RegWrite  = wb_rw_q;
  assign WB_MemtoReg  = wb_m2r_q;
  assign WB_WriteReg  = wb_wreg_q;
  assign WB_ALUanswer = wb_alu_q;
  assign WB_MemData   = wb_md_q;
  assign WB_PC        = wb_pc_q;
  assign WB_AddrErr   = wb_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, reset/misalign sequences and random ops
// against a byte-addressed memory model.
module tb_mem_access_stage;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clock, reset;
  logic        ME_RegWrite, ME_MemtoReg, ME_MemWrite;
  logic [4:0]  ME_WriteReg;
  logic [31:0] ME_ALUanswer, ME_Qb, ME_PC;
  logic [2:0]  ME_load_option;
  logic [1:0]  ME_save_option;
  logic        ME_stall;
  logic        WB_RegWrite, WB_MemtoReg, WB_AddrErr;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_ALUanswer, WB_MemData, WB_PC;

  mem_access_stage #(.DEPTH_WORDS(DEPTH), .MEM_LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .ME_RegWrite(ME_RegWrite), .ME_MemtoReg(ME_MemtoReg), .ME_MemWrite(ME_MemWrite),
    .ME_WriteReg(ME_WriteReg), .ME_ALUanswer(ME_ALUanswer), .ME_Qb(ME_Qb),
    .ME_load_option(ME_load_option), .ME_save_option(ME_save_option), .ME_PC(ME_PC),
    .ME_stall(ME_stall),
    .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg), .WB_WriteReg(WB_WriteReg),
    .WB_ALUanswer(WB_ALUanswer), .WB_MemData(WB_MemData), .WB_PC(WB_PC),
    .WB_AddrErr(WB_AddrErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rw, m2r, mw;
    logic [4:0]  wreg;
    logic [31:0] addr, qb, pc;
    logic [2:0]  lopt;
    logic [1:0]  sopt;
    logic [31:0] exp_md;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [7:0] mbytes [DEPTH*4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wb_any();
    return 32'(|{WB_RegWrite, WB_MemtoReg, WB_WriteReg, WB_ALUanswer, WB_MemData, WB_PC, WB_AddrErr});
  endfunction

  function automatic int acc_size(vec_t v);
    if (v.mw) return (v.sopt == 2'd1) ? 1 : (v.sopt == 2'd2) ? 2 : 4;
    if (v.lopt == 3'd1 || v.lopt == 3'd2) return 1;
    if (v.lopt == 3'd3 || v.lopt == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic model_mis(vec_t v);
`ifdef MEM_MISALIGN_CHECK_EN
    if (!(v.m2r || v.mw)) return 1'b0;
    return (v.addr % 32'(acc_size(v))) != 32'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int base_of(vec_t v);
    int a;
    a = int'(v.addr % 32'(DEPTH*4));
    return a - (a % acc_size(v));
  endfunction

  function automatic logic [31:0] model_load(vec_t v);
    int sz, b;
    logic [31:0] val;
    sz = acc_size(v);
    b = base_of(v);
    val = 32'd0;
    for (int i = 0; i < sz; i++) val |= 32'(mbytes[b+i]) << (8*i);
    if ((v.lopt == 3'd1 || v.lopt == 3'd3) && val[8*sz-1])
      val |= ~((32'd1 << (8*sz)) - 32'd1);
    return val;
  endfunction

  task automatic model_store(vec_t v);
    int sz, b;
    logic [31:0] d;
    sz = acc_size(v);
    b = base_of(v);
    d = v.qb;
    for (int i = 0; i < sz; i++) mbytes[b+i] = d[8*i +: 8];
  endtask

  function automatic vec_t mk(logic m2r, logic mw, logic rw, logic [2:0] lopt, logic [1:0] sopt,
                              logic [31:0] addr, logic [31:0] qb, logic [31:0] exp_md);
    vec_t v;
    v.m2r = m2r; v.mw = mw; v.rw = rw; v.lopt = lopt; v.sopt = sopt;
    v.addr = addr; v.qb = qb; v.exp_md = exp_md;
    v.wreg = addr[6:2] ^ 5'd3;
    v.pc = addr ^ 32'h0040_0000;
    return v;
  endfunction

  task automatic drive(vec_t v);
    ME_RegWrite = v.rw; ME_MemtoReg = v.m2r; ME_MemWrite = v.mw;
    ME_WriteReg = v.wreg; ME_ALUanswer = v.addr; ME_Qb = v.qb;
    ME_load_option = v.lopt; ME_save_option = v.sopt; ME_PC = v.pc;
  endtask

  // Drives one instruction at posedge+1, counts stall cycles, returns at posedge+1 after completion.
  task automatic do_op(vec_t v, string tag);
    int st;
    logic mis, ld;
    logic [31:0] e_md;
    drive(v);
    mis  = model_mis(v);
    ld   = v.m2r && !v.mw;
    e_md = (ld && !mis) ? model_load(v) : 32'd0;
    st = 0;
    #1;
    while (ME_stall === 1'b1 && st < 20) begin
      @(posedge clock); #1;
      st++;
      chk({tag, "_bubble"}, wb_any(), 32'd0);
    end
    chk({tag, "_stall_cycles"}, 32'(st), (v.m2r || v.mw) ? 32'(LAT) : 32'd0);
    @(posedge clock); #1;
    if (v.mw && !mis) model_store(v);
    chk({tag, "_rw"},   32'(WB_RegWrite), 32'(v.rw && !mis));
    chk({tag, "_m2r"},  32'(WB_MemtoReg), 32'(v.m2r));
    chk({tag, "_wreg"}, 32'(WB_WriteReg), 32'(v.wreg));
    chk({tag, "_alu"},  WB_ALUanswer, v.addr);
    chk({tag, "_md"},   WB_MemData, e_md);
    chk({tag, "_pc"},   WB_PC, v.pc);
    chk({tag, "_err"},  32'(WB_AddrErr), 32'(mis));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [31:0] r1, r2;
    int kind;

    for (int i = 0; i < DEPTH*4; i++) mbytes[i] = 8'd0;

    // Reset with a non-memory instruction waiting at the input
    v = mk(1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 32'h1234, 32'd0, 32'd0);
    v.wreg = 5'd5;
    drive(v);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk($sformatf("reset%0d_wb", i), wb_any(), 32'd0);
      chk($sformatf("reset%0d_stall", i), 32'(ME_stall), 32'd0);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_reset_alu", WB_ALUanswer, 32'h1234);
    chk("post_reset_wreg", 32'(WB_WriteReg), 32'd5);
    chk("post_reset_rw", 32'(WB_RegWrite), 32'd1);
    chk("post_reset_stall", 32'(ME_stall), 32'd0);

    tbl.push_back(mk(0, 1, 0, 3'd0, 2'd0, 32'h10, 32'hAABBCCDD, 32'd0));
    tbl.push_back(mk(1, 0, 1, 3'd1, 2'd0, 32'h13, 32'd0, 32'hFFFFFFAA));
    tbl.push_back(mk(1, 0, 1, 3'd2, 2'd0, 32'h13, 32'd0, 32'h000000AA));
    tbl.push_back(mk(1, 0, 1, 3'd3, 2'd0, 32'h12, 32'd0, 32'hFFFFAABB));
    tbl.push_back(mk(1, 0, 1, 3'd4, 2'd0, 32'h12, 32'd0, 32'h0000AABB));
    tbl.push_back(mk(1, 0, 1, 3'd0, 2'd0, 32'h10, 32'd0, 32'hAABBCCDD));
    tbl.push_back(mk(1, 0, 1, 3'd1, 2'd0, 32'h10, 32'd0, 32'hFFFFFFDD));
    tbl.push_back(mk(1, 0, 1, 3'd2, 2'd0, 32'h11, 32'd0, 32'h000000CC));
    tbl.push_back(mk(1, 0, 1, 3'd3, 2'd0, 32'h10, 32'd0, 32'hFFFFCCDD));
    tbl.push_back(mk(1, 0, 1, 3'd4, 2'd0, 32'h10, 32'd0, 32'h0000CCDD));
    tbl.push_back(mk(0, 1, 0, 3'd0, 2'd2, 32'h12, 32'h55551234, 32'd0));
    tbl.push_back(mk(1, 0, 1, 3'd6, 2'd0, 32'h10, 32'd0, 32'h1234CCDD));
    tbl.push_back(mk(1, 0, 1, 3'd0, 2'd0, 32'h1010, 32'd0, 32'h1234CCDD));
    tbl.push_back(mk(0, 1, 0, 3'd0, 2'd0, 32'h20, 32'h0, 32'd0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 2'd1, 32'h21, 32'h1234567F, 32'd0));
    tbl.push_back(mk(1, 0, 1, 3'd0, 2'd0, 32'h20, 32'd0, 32'h00007F00));
    tbl.push_back(mk(0, 1, 0, 3'd0, 2'd3, 32'h40, 32'h11111111, 32'd0));
    tbl.push_back(mk(1, 1, 1, 3'd0, 2'd0, 32'h44, 32'h0BADF00D, 32'd0));
    tbl.push_back(mk(1, 0, 1, 3'd0, 2'd0, 32'h44, 32'd0, 32'h0BADF00D));
    tbl.push_back(mk(0, 1, 0, 3'd0, 2'd0, 32'h30, 32'h0, 32'd0));
    tbl.push_back(mk(0, 0, 1, 3'd0, 2'd0, 32'hCAFE, 32'h0, 32'd0));
    foreach (tbl[i]) begin
      do_op(tbl[i], $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_exp_md", i), WB_MemData, tbl[i].exp_md);
    end

    // Store interrupted by reset in its second wait cycle is dropped
    v = mk(0, 1, 0, 3'd0, 2'd0, 32'h40, 32'hDEADBEEF, 32'd0);
    drive(v);
    #1;
    chk("rst_wait_stall0", 32'(ME_stall), 32'd1);
    @(posedge clock); #1;
    chk("rst_wait_stall1", 32'(ME_stall), 32'd1);
    reset = 1'b1;
    v = mk(1, 0, 1, 3'd0, 2'd0, 32'h40, 32'd0, 32'h11111111);
    drive(v);
    @(posedge clock); #1;
    chk("rst_wait_wb", wb_any(), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_wait_restart", 32'(ME_stall), 32'd1);
    do_op(v, "rst_wait_lw");
    chk("rst_wait_lw_data", WB_MemData, 32'h11111111);

    // Halfword store at an odd address
    v = mk(0, 1, 1, 3'd0, 2'd2, 32'h31, 32'h0000BEEF, 32'd0);
    do_op(v, "mis_sh");
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_sh_err", 32'(WB_AddrErr), 32'd1);
    chk("mis_sh_rw", 32'(WB_RegWrite), 32'd0);
    v = mk(1, 0, 1, 3'd0, 2'd0, 32'h30, 32'd0, 32'h00000000);
`else
    chk("mis_sh_err", 32'(WB_AddrErr), 32'd0);
    chk("mis_sh_rw", 32'(WB_RegWrite), 32'd1);
    v = mk(1, 0, 1, 3'd0, 2'd0, 32'h30, 32'd0, 32'h0000BEEF);
`endif
    do_op(v, "mis_lw");
    chk("mis_lw_data", WB_MemData, v.exp_md);

    // Random traffic over RAM words 0..15 with junk in the ignored high address bits
    for (int w = 0; w < 16; w++)
      do_op(mk(0, 1, 0, 3'd0, 2'd0, 32'(w*4), 32'd0, 32'd0), "init");
    for (int n = 0; n < 300; n++) begin
      r1 = $urandom;
      r2 = $urandom;
      kind = $urandom_range(0, 7);
      v.m2r = (kind >= 2 && kind <= 4) || kind == 7;
      v.mw  = (kind >= 5);
      v.rw  = r2[31];
      v.wreg = r2[30:26];
      v.lopt = r2[25:23];
      v.sopt = r2[22:21];
      v.addr = {r1[31:12], 6'd0, r2[5:0]};
      v.qb   = $urandom;
      v.pc   = $urandom;
      v.exp_md = 32'd0;
      do_op(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
